// File: rtl/prach_hb2_sched_if.sv
// Sample stream into the PRACH half-band scheduler and the slot-ordered stream out to hb2.
// master drives the input beats; slave is the scheduler side.
interface prach_hb2_sched_if #(
    parameter int DW = 16
) ();
    logic [DW-1:0] din_dq;
    logic          din_dv;
    logic [7:0]    din_chn;
    logic          sync_in;
    logic [DW-1:0] dout_dp1;
    logic [DW-1:0] dout_dp2;
    logic          dout_dv;
    logic [7:0]    dout_chn;
    logic          sync_out;

    modport master (
        output din_dq, din_dv, din_chn, sync_in,
        input  dout_dp1, dout_dp2, dout_dv, dout_chn, sync_out
    );

    modport slave (
        input  din_dq, din_dv, din_chn, sync_in,
        output dout_dp1, dout_dp2, dout_dv, dout_chn, sync_out
    );
endinterface

// File: rtl/prach_hb2_sched.sv
// Double-banked reorder buffer: collects two phases per channel, then replays a full
// bank as one TDM round of NUM_CHN slots, or a bubble round when no bank is ready.
module prach_hb2_sched #(
    parameter int NUM_CHN = 32,
    parameter int DW      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clr,
    prach_hb2_sched_if.slave     bus,
    output logic                 ovf,
    output logic                 unf,
    output logic                 chn_err
);
    localparam int CW = $clog2(NUM_CHN);
    localparam int NW = $clog2(2 * NUM_CHN + 1);
    localparam logic [CW-1:0] LAST_SLOT = CW'(NUM_CHN - 1);
    localparam logic [NW-1:0] LAST_WR   = NW'(2 * NUM_CHN - 1);

    typedef enum logic [1:0] {S_IDLE, S_VALID, S_BUBBLE} round_t;

    logic [DW-1:0]      mem_dp1 [2][NUM_CHN];
    logic [DW-1:0]      mem_dp2 [2][NUM_CHN];
    logic [NUM_CHN-1:0] phase     [2];
    logic [NUM_CHN-1:0] pair_done [2];
    logic [NW-1:0]      wr_cnt    [2];
    logic [1:0]         full;
    logic [1:0]         sync_tag;
    logic               wr_bank;
    logic               rd_bank;
    logic [CW-1:0]      slot;
    logic               seen_valid;

    round_t state, next_state, cur_round;

    logic [CW-1:0] widx;
    logic          in_range;
    logic          accept;
    logic          ovf_set;
    logic          err_set;
    logic          unf_set;
    logic          round_end;

    logic [DW-1:0] dp1_d, dp2_d, dp1_q, dp2_q;
    logic [7:0]    chn_d, chn_q;
    logic          dv_d, dv_q, sync_d, sync_q;

    // A beat is dropped when its bank is full or its channel already holds both phases.
    assign widx      = bus.din_chn[CW-1:0];
    assign in_range  = (32'(bus.din_chn) < NUM_CHN);
    assign accept    = bus.din_dv & in_range & ~full[wr_bank] & ~pair_done[wr_bank][widx];
    assign ovf_set   = bus.din_dv & in_range & (full[wr_bank] | pair_done[wr_bank][widx]);
    assign err_set   = bus.din_dv & ~in_range;
    assign unf_set   = (cur_round == S_BUBBLE) && (slot == '0) && seen_valid;
    assign round_end = (cur_round == S_VALID) && (slot == LAST_SLOT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The round type is decided only at slot 0, from the read bank's full flag.
    always_comb begin
        cur_round  = state;
        next_state = state;
        if (slot == '0) begin
            if (!en) begin
                cur_round = S_IDLE;
            end else if (full[rd_bank]) begin
                cur_round = S_VALID;
            end else begin
                cur_round = S_BUBBLE;
            end
        end
        next_state = cur_round;
        if (slot == LAST_SLOT) begin
            next_state = S_IDLE;
        end
    end

    always_comb begin
        dv_d   = 1'b0;
        dp1_d  = '0;
        dp2_d  = '0;
        sync_d = 1'b0;
        chn_d  = 8'(slot);
        if (cur_round == S_VALID) begin
            dv_d   = 1'b1;
            dp1_d  = mem_dp1[rd_bank][slot];
            dp2_d  = mem_dp2[rd_bank][slot];
            sync_d = (slot == '0) && sync_tag[rd_bank];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot       <= '0;
            seen_valid <= 1'b0;
            dv_q       <= 1'b0;
            dp1_q      <= '0;
            dp2_q      <= '0;
            chn_q      <= '0;
            sync_q     <= 1'b0;
        end else begin
            if (cur_round != S_IDLE) begin
                slot <= slot + CW'(1);
            end
            if ((cur_round == S_VALID) && (slot == '0)) begin
                seen_valid <= 1'b1;
            end
            dv_q   <= dv_d;
            dp1_q  <= dp1_d;
            dp2_q  <= dp2_d;
            chn_q  <= chn_d;
            sync_q <= sync_d;
        end
    end

    assign bus.dout_dv  = dv_q;
    assign bus.dout_dp1 = dp1_q;
    assign bus.dout_dp2 = dp2_q;
    assign bus.dout_chn = chn_q;
    assign bus.sync_out = sync_q;

    // Phase 0 lands in the dp2 entry, phase 1 in dp1.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (phase[wr_bank][widx]) begin
                mem_dp1[wr_bank][widx] <= bus.din_dq;
            end else begin
                mem_dp2[wr_bank][widx] <= bus.din_dq;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full     <= '0;
            sync_tag <= '0;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                phase[b]     <= '0;
                pair_done[b] <= '0;
                wr_cnt[b]    <= '0;
            end
        end else begin
            if (accept) begin
                phase[wr_bank][widx] <= ~phase[wr_bank][widx];
                if (phase[wr_bank][widx]) begin
                    pair_done[wr_bank][widx] <= 1'b1;
                end
                wr_cnt[wr_bank] <= wr_cnt[wr_bank] + NW'(1);
                if (bus.sync_in) begin
                    sync_tag[wr_bank] <= 1'b1;
                end
                if (wr_cnt[wr_bank] == LAST_WR) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                end
            end
            // A bank being read is full, so it can never be the bank written above.
            if (round_end) begin
                full[rd_bank]      <= 1'b0;
                sync_tag[rd_bank]  <= 1'b0;
                phase[rd_bank]     <= '0;
                pair_done[rd_bank] <= '0;
                wr_cnt[rd_bank]    <= '0;
                rd_bank            <= ~rd_bank;
            end
        end
    end

    // Sticky flags: a new event in the same cycle as clr keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf     <= 1'b0;
            unf     <= 1'b0;
            chn_err <= 1'b0;
        end else begin
            ovf     <= ovf_set | (ovf & ~clr);
            unf     <= unf_set | (unf & ~clr);
            chn_err <= err_set | (chn_err & ~clr);
        end
    end
endmodule

// File: tb/tb_prach_hb2_sched.sv
// Directed bench for prach_hb2_sched: flag vectors from a table plus hand-built round sequences.
module tb_prach_hb2_sched;
    localparam int NUM_CHN = 32;
    localparam int DW      = 16;

    typedef struct {
        logic        dv;
        logic [7:0]  chn;
        logic [15:0] dq;
        logic        clr;
        logic        exp_ovf;
        logic        exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst, en, clr;
    logic ovf, unf, chn_err;
    int   checks   = 0;
    int   failures = 0;
    int   tb_slot  = 0;
    int   out_slot = 0;
    vec_t vecs [8];

    prach_hb2_sched_if #(.DW(DW)) bus ();

    prach_hb2_sched #(.NUM_CHN(NUM_CHN), .DW(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .clr     (clr),
        .bus     (bus),
        .ovf     (ovf),
        .unf     (unf),
        .chn_err (chn_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h slot=%0d", name, actual, expected, out_slot);
        end
    endtask

    task automatic applyStimulus(input logic dv, input logic [7:0] chn, input logic [15:0] dq,
                                 input logic sync, input logic clr_v);
        bus.din_dv  = dv;
        bus.din_chn = chn;
        bus.din_dq  = dq;
        bus.sync_in = sync;
        clr         = clr_v;
    endtask

    // Advance one clock; out_slot is the slot whose registered output is now visible.
    task automatic tick();
        int prev;
        prev = tb_slot;
        @(posedge clk);
        #1;
        out_slot = prev;
        if (rst) tb_slot = 0;
        else if (tb_slot != 0 || en) tb_slot = (tb_slot + 1) % NUM_CHN;
    endtask

    task automatic feedBank(input int base, input logic first_sync, input int skip);
        logic first;
        first = 1'b1;
        for (int p = 0; p < 2; p++) begin
            for (int c = 0; c < NUM_CHN; c++) begin
                if (c != skip) begin
                    applyStimulus(1'b1, 8'(c), 16'(base + 2 * c + p), first_sync & first, 1'b0);
                    first = 1'b0;
                    tick();
                    checkOutput("feed_dv", bus.dout_dv, 0);
                end
            end
        end
        applyStimulus(1'b0, 8'd0, 16'd0, 1'b0, 1'b0);
    endtask

    task automatic checkRound(input int base, input logic sync_exp);
        for (int s = 0; s < NUM_CHN; s++) begin
            tick();
            checkOutput("round_dv", bus.dout_dv, 1);
            checkOutput("round_chn", bus.dout_chn, s);
            checkOutput("round_dp2", bus.dout_dp2, 32'(base + 2 * s));
            checkOutput("round_dp1", bus.dout_dp1, 32'(base + 2 * s + 1));
            checkOutput("round_sync", bus.sync_out, (s == 0) ? 32'(sync_exp) : 0);
        end
    endtask

    task automatic checkBubble(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            checkOutput("bubble_dv", bus.dout_dv, 0);
            checkOutput("bubble_chn", bus.dout_chn, out_slot);
            checkOutput("bubble_dp1", bus.dout_dp1, 0);
            checkOutput("bubble_dp2", bus.dout_dp2, 0);
            checkOutput("bubble_sync", bus.sync_out, 0);
        end
    endtask

    initial begin
        // Flag behaviour into bank B: range errors, third beat per channel, clr versus set.
        vecs[0] = '{dv: 1'b1, chn: 8'd40,  dq: 16'h0000, clr: 1'b0, exp_ovf: 1'b0, exp_err: 1'b1};
        vecs[1] = '{dv: 1'b0, chn: 8'd0,   dq: 16'h0000, clr: 1'b1, exp_ovf: 1'b0, exp_err: 1'b0};
        vecs[2] = '{dv: 1'b1, chn: 8'd3,   dq: 16'h0106, clr: 1'b0, exp_ovf: 1'b0, exp_err: 1'b0};
        vecs[3] = '{dv: 1'b1, chn: 8'd3,   dq: 16'h0107, clr: 1'b0, exp_ovf: 1'b0, exp_err: 1'b0};
        vecs[4] = '{dv: 1'b1, chn: 8'd3,   dq: 16'hbeef, clr: 1'b0, exp_ovf: 1'b1, exp_err: 1'b0};
        vecs[5] = '{dv: 1'b1, chn: 8'd3,   dq: 16'hbeef, clr: 1'b1, exp_ovf: 1'b1, exp_err: 1'b0};
        vecs[6] = '{dv: 1'b1, chn: 8'd200, dq: 16'h0000, clr: 1'b1, exp_ovf: 1'b0, exp_err: 1'b1};
        vecs[7] = '{dv: 1'b0, chn: 8'd0,   dq: 16'h0000, clr: 1'b1, exp_ovf: 1'b0, exp_err: 1'b0};

        rst = 1'b1;
        en  = 1'b0;
        applyStimulus(1'b0, 8'd0, 16'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("rst_dv", bus.dout_dv, 0);
            checkOutput("rst_chn", bus.dout_chn, 0);
            checkOutput("rst_dp1", bus.dout_dp1, 0);
            checkOutput("rst_dp2", bus.dout_dp2, 0);
            checkOutput("rst_sync", bus.sync_out, 0);
            checkOutput("rst_ovf", ovf, 0);
            checkOutput("rst_unf", unf, 0);
            checkOutput("rst_err", chn_err, 0);
        end
        rst = 1'b0;
        en  = 1'b1;

        $display("[TB] three idle bubble rounds");
        checkBubble(3 * NUM_CHN);
        checkOutput("unf_before_valid", unf, 0);

        $display("[TB] fill bank A and replay it");
        feedBank(0, 1'b1, -1);
        checkRound(0, 1'b1);
        tick();
        checkOutput("bubble_after_valid_dv", bus.dout_dv, 0);
        checkOutput("unf_after_bubble", unf, 1);

        $display("[TB] flag vector table");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].dv, vecs[i].chn, vecs[i].dq, 1'b0, vecs[i].clr);
            tick();
            checkOutput($sformatf("vec%0d_ovf", i), ovf, 32'(vecs[i].exp_ovf));
            checkOutput($sformatf("vec%0d_chn_err", i), chn_err, 32'(vecs[i].exp_err));
        end
        applyStimulus(1'b0, 8'd0, 16'd0, 1'b0, 1'b0);

        $display("[TB] bank B completes at slot 5");
        for (int i = 0; i < NUM_CHN && tb_slot != 8; i++) tick();
        feedBank(16'h100, 1'b0, 3);
        for (int i = 0; i < NUM_CHN && tb_slot != 0; i++) begin
            tick();
            checkOutput("no_early_emit", bus.dout_dv, 0);
        end
        checkRound(16'h100, 1'b0);

        $display("[TB] both banks full then one extra beat");
        en = 1'b0;
        feedBank(16'h200, 1'b1, -1);
        feedBank(16'h300, 1'b0, -1);
        checkOutput("ovf_before_extra", ovf, 0);
        applyStimulus(1'b1, 8'd5, 16'hdead, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 8'd0, 16'd0, 1'b0, 1'b0);
        checkOutput("ovf_extra_beat", ovf, 1);
        en = 1'b1;
        checkRound(16'h200, 1'b1);
        checkRound(16'h300, 1'b0);

        $display("[TB] reset in the middle of a valid round");
        en = 1'b0;
        feedBank(16'h400, 1'b0, -1);
        en = 1'b1;
        for (int s = 0; s < 10; s++) begin
            tick();
            checkOutput("pre_rst_dv", bus.dout_dv, 1);
            checkOutput("pre_rst_dp2", bus.dout_dp2, 32'(16'h400 + 2 * s));
        end
        rst = 1'b1;
        tick();
        checkOutput("mid_rst_dv", bus.dout_dv, 0);
        checkOutput("mid_rst_chn", bus.dout_chn, 0);
        checkOutput("mid_rst_dp1", bus.dout_dp1, 0);
        checkOutput("mid_rst_dp2", bus.dout_dp2, 0);
        checkOutput("mid_rst_ovf", ovf, 0);
        rst = 1'b0;
        checkBubble(2 * NUM_CHN);
        checkOutput("unf_after_rst", unf, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
